pipe_hazard_ctrl: RTL and testbench

- Central pipeline control unit for the dual-issue core. Drives the per-register Stall, Flush and issue_select inputs of the four pipeline registers: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Sequences multi-cycle conditions with an FSM and counters: data-memory wait, MDU busy, and redirect bubbles after a mispredict or trap.
- Resolves simultaneous hazards by a fixed priority.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 37 +++
 rtl/pipe_perf_cnt.sv | 29 ++
 rtl/pipe_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   - state_t      : 2-bit FSM state encoding (RUN, MEM_WAIT, MDU_BUSY, REDIRECT)
//   - SLOT0/SLOT1  : issue-slot indices of the dual-issue core
//   - REDIRECT_CYCLES_DEFAULT : default number of IF/ID flush cycles after a redirect
//   - RCNT_WIDTH   : width of the redirect counter (covers the legal range 1..15)
//   - PREG_*       : bit positions of the four pipeline registers in stall/flush vectors
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MDU_BUSY = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  localparam logic SLOT0 = 1'b0;
  localparam logic SLOT1 = 1'b1;

  localparam int REDIRECT_CYCLES_DEFAULT = 2;
  localparam int RCNT_WIDTH              = 4;

  // Index of each pipeline register inside the internal 4-bit stall/flush vectors.
  localparam int PREG_IFID  = 0;
  localparam int PREG_IDEX  = 1;
  localparam int PREG_EXMEM = 2;
  localparam int PREG_MEMWB = 3;

  // A slot-0 branch has a younger slot-1 partner on the wrong path that must be
  // killed in EX/MEM; a slot-1 branch is the younger of the pair, so EX/MEM is kept.
  function automatic logic br_kills_partner(input logic slot);
    return (slot == SLOT0) && (slot != SLOT1);
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// -----------------------------------------------------------------------------
// pipe_perf_cnt
// Saturating, synchronously clearable event counter.
// Ports:
//   clk    in   clock
//   rst_n  in   synchronous active-low reset, clears the count
//   clr    in   synchronous clear, clears the count
//   inc    in   count this cycle
//   count  out  WIDTH-bit count, sticks at all-ones
// -----------------------------------------------------------------------------
module pipe_perf_cnt #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central pipeline control for the dual-issue core. Generates Stall/Flush for the
// IF/ID, ID/EX, EX/MEM and MEM/WB registers and the EX/MEM issue_select, and
// sequences data-memory waits, MDU busy periods and post-redirect bubbles.
//
// Optional feature macro: PIPE_CTRL_PERF_EN (adds perf_clr, perf_stall_cyc,
// perf_flush_cyc; functional outputs are identical either way).
//
// Parameters:
//   REDIRECT_CYCLES  IF/ID flush cycles following a redirect (1..15)
//   CNT_WIDTH        performance counter width (only used with the perf macro)
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   load_use[1:0]      ID-stage load-use hazard per issue slot
//   br_mispredict      EX-stage mispredict pulse, br_slot = its issue slot
//   trap_redirect      MEM-stage trap/mret redirect pulse
//   dmem_req/ready     MEM-stage data access and its response
//   mdu_start/done     MDU issue pulse and result-valid pulse
//   stall_*, flush_*   to the four pipeline registers
//   sel_exmem          1: EX/MEM flush kills slot 1 only
//   busy               FSM is not in RUN
//   perf_*             (macro only) cycle counters with synchronous clear
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REDIRECT_CYCLES = REDIRECT_CYCLES_DEFAULT,
  parameter int CNT_WIDTH       = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] load_use,
  input  logic       br_mispredict,
  input  logic       br_slot,
  input  logic       trap_redirect,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  input  logic       mdu_start,
  input  logic       mdu_done,
  output logic       stall_ifid,
  output logic       stall_idex,
  output logic       stall_exmem,
  output logic       stall_memwb,
  output logic       flush_ifid,
  output logic       flush_idex,
  output logic       flush_exmem,
  output logic       flush_memwb,
  output logic       sel_exmem,
  output logic       busy
`ifdef PIPE_CTRL_PERF_EN
  ,
  input  logic                 perf_clr,
  output logic [CNT_WIDTH-1:0] perf_stall_cyc,
  output logic [CNT_WIDTH-1:0] perf_flush_cyc
`endif
);

  // Elaboration-time guard on the parameter ranges.
  if (REDIRECT_CYCLES < 1 || REDIRECT_CYCLES > 15 || CNT_WIDTH < 1) begin : g_param_check
    $error("pipe_hazard_ctrl: REDIRECT_CYCLES must be 1..15 and CNT_WIDTH >= 1");
  end

  // Counter holds "remaining REDIRECT cycles minus one"; the FSM leaves
  // REDIRECT after the cycle in which it reads 0.
  localparam logic [RCNT_WIDTH-1:0] RCNT_RELOAD = RCNT_WIDTH'(REDIRECT_CYCLES - 1);

  state_t                  state_reg, state_next;
  logic [RCNT_WIDTH-1:0]   rcnt_reg, rcnt_next;

  // Internal, ungated control vectors indexed by PREG_*.
  logic [3:0] stall_c;
  logic [3:0] flush_c;
  logic       sel_c;

  logic mem_wait;
  logic mdu_wait;

  assign mem_wait = dmem_req & ~dmem_ready;
  assign mdu_wait = mdu_start & ~mdu_done;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_RUN;
      rcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      rcnt_reg  <= rcnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_c    = 4'b0000;
    flush_c    = 4'b0000;
    sel_c      = 1'b0;
    state_next = state_reg;
    rcnt_next  = rcnt_reg;

    if (trap_redirect) begin
      // A trap outranks everything in every state, including pending waits.
      flush_c    = 4'b1111;
      state_next = ST_REDIRECT;
      rcnt_next  = RCNT_RELOAD;
    end else begin
      unique case (state_reg)
        ST_RUN: begin
          if (br_mispredict) begin
            flush_c[PREG_IFID]  = 1'b1;
            flush_c[PREG_IDEX]  = 1'b1;
            flush_c[PREG_EXMEM] = br_kills_partner(br_slot);
            sel_c               = br_kills_partner(br_slot);
            state_next          = ST_REDIRECT;
            rcnt_next           = RCNT_RELOAD;
          end else if (mem_wait) begin
            stall_c[PREG_IFID]  = 1'b1;
            stall_c[PREG_IDEX]  = 1'b1;
            stall_c[PREG_EXMEM] = 1'b1;
            flush_c[PREG_MEMWB] = 1'b1;
            state_next          = ST_MEM_WAIT;
          end else if (mdu_wait) begin
            stall_c[PREG_IFID]  = 1'b1;
            stall_c[PREG_IDEX]  = 1'b1;
            flush_c[PREG_EXMEM] = 1'b1;
            state_next          = ST_MDU_BUSY;
          end else if (|load_use) begin
            stall_c[PREG_IFID]  = 1'b1;
            flush_c[PREG_IDEX]  = 1'b1;
          end
        end

        ST_MEM_WAIT: begin
          // EX is frozen here, so a mispredict or MDU start seen now will be
          // presented again once the access completes; they are not acted on.
          if (mem_wait) begin
            stall_c[PREG_IFID]  = 1'b1;
            stall_c[PREG_IDEX]  = 1'b1;
            stall_c[PREG_EXMEM] = 1'b1;
            flush_c[PREG_MEMWB] = 1'b1;
          end else begin
            state_next = ST_RUN;
          end
        end

        ST_MDU_BUSY: begin
          if (!mdu_done) begin
            stall_c[PREG_IFID]  = 1'b1;
            stall_c[PREG_IDEX]  = 1'b1;
            flush_c[PREG_EXMEM] = 1'b1;
          end else begin
            state_next = ST_RUN;
          end
        end

        ST_REDIRECT: begin
          flush_c[PREG_IFID] = 1'b1;
          if (br_mispredict) begin
            flush_c[PREG_IDEX]  = 1'b1;
            flush_c[PREG_EXMEM] = br_kills_partner(br_slot);
            sel_c               = br_kills_partner(br_slot);
            rcnt_next           = RCNT_RELOAD;
          end else if (mem_wait) begin
            // IF/ID is being flushed, so its stall is withheld; the redirect
            // countdown pauses until the access completes.
            stall_c[PREG_IDEX]  = 1'b1;
            stall_c[PREG_EXMEM] = 1'b1;
            flush_c[PREG_MEMWB] = 1'b1;
          end else if (rcnt_reg == '0) begin
            state_next = ST_RUN;
          end else begin
            rcnt_next = rcnt_reg - 1'b1;
          end
        end

        default: begin
          state_next = ST_RUN;
          rcnt_next  = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: forced low while reset is held.
  // ---------------------------------------------------------------------------
  assign stall_ifid  = rst_n & stall_c[PREG_IFID];
  assign stall_idex  = rst_n & stall_c[PREG_IDEX];
  assign stall_exmem = rst_n & stall_c[PREG_EXMEM];
  assign stall_memwb = rst_n & stall_c[PREG_MEMWB];
  assign flush_ifid  = rst_n & flush_c[PREG_IFID];
  assign flush_idex  = rst_n & flush_c[PREG_IDEX];
  assign flush_exmem = rst_n & flush_c[PREG_EXMEM];
  assign flush_memwb = rst_n & flush_c[PREG_MEMWB];
  assign sel_exmem   = rst_n & sel_c;
  assign busy        = rst_n & (state_reg != ST_RUN);

`ifdef PIPE_CTRL_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters: cycles with any stall / any flush asserted.
  // ---------------------------------------------------------------------------
  logic any_stall;
  logic any_flush;

  assign any_stall = stall_ifid | stall_idex | stall_exmem | stall_memwb;
  assign any_flush = flush_ifid | flush_idex | flush_exmem | flush_memwb;

  pipe_perf_cnt #(
    .WIDTH (CNT_WIDTH)
  ) u_perf_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (perf_clr),
    .inc   (any_stall),
    .count (perf_stall_cyc)
  );

  pipe_perf_cnt #(
    .WIDTH (CNT_WIDTH)
  ) u_perf_flush (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (perf_clr),
    .inc   (any_flush),
    .count (perf_flush_cyc)
  );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl. A behavioural model tracks the pending
// condition (memory wait, MDU wait, remaining redirect bubbles) and derives the
// expected control outputs; a negedge process compares every output each cycle.
// Literal expectations inside the stimulus pin the model to hand-derived values.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int R  = 2;
  localparam int CW = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] load_use = 2'b00;
  logic       br_mispredict = 1'b0;
  logic       br_slot = 1'b0;
  logic       trap_redirect = 1'b0;
  logic       dmem_req = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       mdu_start = 1'b0;
  logic       mdu_done = 1'b0;
  logic       stall_ifid, stall_idex, stall_exmem, stall_memwb;
  logic       flush_ifid, flush_idex, flush_exmem, flush_memwb;
  logic       sel_exmem, busy;
`ifdef PIPE_CTRL_PERF_EN
  logic          perf_clr = 1'b0;
  logic [CW-1:0] perf_stall_cyc, perf_flush_cyc;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REDIRECT_CYCLES (R),
    .CNT_WIDTH       (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_use      (load_use),
    .br_mispredict (br_mispredict),
    .br_slot       (br_slot),
    .trap_redirect (trap_redirect),
    .dmem_req      (dmem_req),
    .dmem_ready    (dmem_ready),
    .mdu_start     (mdu_start),
    .mdu_done      (mdu_done),
    .stall_ifid    (stall_ifid),
    .stall_idex    (stall_idex),
    .stall_exmem   (stall_exmem),
    .stall_memwb   (stall_memwb),
    .flush_ifid    (flush_ifid),
    .flush_idex    (flush_idex),
    .flush_exmem   (flush_exmem),
    .flush_memwb   (flush_memwb),
    .sel_exmem     (sel_exmem),
    .busy          (busy)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_clr       (perf_clr),
    .perf_stall_cyc (perf_stall_cyc),
    .perf_flush_cyc (perf_flush_cyc)
`endif
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Model state: which condition is pending and how many bubbles remain.
  // ---------------------------------------------------------------------------
  bit in_mem  = 1'b0;
  bit in_mdu  = 1'b0;
  int red_left = 0;
  bit seen_rst = 1'b0;

  // Layout: [3:0] stall {memwb,exmem,idex,ifid}, [7:4] flush (same order),
  // [8] sel_exmem, [9] busy.
  function automatic logic [9:0] expect_now();
    logic [3:0] st;
    logic [3:0] fl;
    logic       sel;
    logic       mw;
    logic       bsy;
    st  = 4'b0000;
    fl  = 4'b0000;
    sel = 1'b0;
    mw  = dmem_req && !dmem_ready;
    bsy = in_mem || in_mdu || (red_left > 0);
    if (!rst_n) return 10'b0;
    if (trap_redirect) begin
      fl = 4'b1111;
    end else if (in_mem) begin
      if (mw) begin st = 4'b0111; fl = 4'b1000; end
    end else if (in_mdu) begin
      if (!mdu_done) begin st = 4'b0011; fl = 4'b0100; end
    end else if (br_mispredict) begin
      fl = 4'b0011;
      if (br_slot == 1'b0) begin fl[2] = 1'b1; sel = 1'b1; end
    end else if (red_left > 0) begin
      fl[0] = 1'b1;
      if (mw) begin st = 4'b0110; fl[3] = 1'b1; end
    end else if (mw) begin
      st = 4'b0111; fl = 4'b1000;
    end else if (mdu_start && !mdu_done) begin
      st = 4'b0011; fl = 4'b0100;
    end else if (load_use != 2'b00) begin
      st = 4'b0001; fl = 4'b0010;
    end
    return {bsy, sel, fl, st};
  endfunction

`ifdef PIPE_CTRL_PERF_EN
  logic [CW-1:0] m_stall_cyc = '0;
  logic [CW-1:0] m_flush_cyc = '0;
`endif

  always @(posedge clk) begin
    logic [9:0] e;
    logic       mw;
    e  = expect_now();
    mw = dmem_req && !dmem_ready;
    if (!rst_n) begin
      in_mem   <= 1'b0;
      in_mdu   <= 1'b0;
      red_left <= 0;
      seen_rst <= 1'b1;
    end else if (trap_redirect) begin
      in_mem   <= 1'b0;
      in_mdu   <= 1'b0;
      red_left <= R;
    end else if (in_mem) begin
      if (!mw) in_mem <= 1'b0;
    end else if (in_mdu) begin
      if (mdu_done) in_mdu <= 1'b0;
    end else if (br_mispredict) begin
      red_left <= R;
    end else if (red_left > 0) begin
      if (!mw) red_left <= red_left - 1;
    end else if (mw) begin
      in_mem <= 1'b1;
    end else if (mdu_start && !mdu_done) begin
      in_mdu <= 1'b1;
    end
`ifdef PIPE_CTRL_PERF_EN
    if (!rst_n || perf_clr) begin
      m_stall_cyc <= '0;
      m_flush_cyc <= '0;
    end else begin
      if ((|e[3:0]) && m_stall_cyc != '1) m_stall_cyc <= m_stall_cyc + 1'b1;
      if ((|e[7:4]) && m_flush_cyc != '1) m_flush_cyc <= m_flush_cyc + 1'b1;
    end
`endif
  end

  string sig_names [10] = '{"stall_ifid", "stall_idex", "stall_exmem", "stall_memwb",
                            "flush_ifid", "flush_idex", "flush_exmem", "flush_memwb",
                            "sel_exmem", "busy"};

  // Compare process: every output, every cycle.
  always @(negedge clk) begin
    logic [9:0] e;
    logic [9:0] a;
    e = expect_now();
    a = {busy, sel_exmem, flush_memwb, flush_exmem, flush_idex, flush_ifid,
         stall_memwb, stall_exmem, stall_idex, stall_ifid};
    for (int i = 0; i < 10; i++) check({"model_", sig_names[i]}, 32'(a[i]), 32'(e[i]));
`ifdef PIPE_CTRL_PERF_EN
    if (seen_rst) begin
      check("model_perf_stall_cyc", perf_stall_cyc, m_stall_cyc);
      check("model_perf_flush_cyc", perf_flush_cyc, m_flush_cyc);
    end
`endif
  end

  // One cycle of stimulus; returns 2 time units after the posedge so the
  // caller can make literal checks on the combinational outputs.
  task automatic apply(input logic [1:0] lu, input logic br, input logic slot,
                       input logic trap, input logic req, input logic rdy,
                       input logic ms, input logic md);
    @(posedge clk);
    #1;
    load_use      = lu;
    br_mispredict = br;
    br_slot       = slot;
    trap_redirect = trap;
    dmem_req      = req;
    dmem_ready    = rdy;
    mdu_start     = ms;
    mdu_done      = md;
    #1;
  endtask

  task automatic idle();
    apply(2'b00, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic set_rst(input logic v);
    @(posedge clk);
    #1;
    rst_n = v;
    #1;
  endtask

  initial begin
    // Reset
    idle();
    idle();
    check("rst_busy", busy, 0);
    check("rst_stall_ifid", stall_ifid, 0);
    set_rst(1'b1);
    idle();
    check("run_idle_busy", busy, 0);

    // Load-use
    apply(2'b01, 0, 0, 0, 0, 0, 0, 0);
    check("lu0_stall_ifid", stall_ifid, 1);
    check("lu0_flush_idex", flush_idex, 1);
    check("lu0_busy", busy, 0);
    idle();
    check("lu0_after_stall_ifid", stall_ifid, 0);
    check("lu0_after_flush_idex", flush_idex, 0);
    apply(2'b10, 0, 0, 0, 0, 0, 0, 0);
    check("lu1_flush_idex", flush_idex, 1);

    // Memory wait: three waiting cycles then the ready cycle
    apply(2'b00, 0, 0, 0, 1, 0, 0, 0);
    check("mw1_stall_exmem", stall_exmem, 1);
    check("mw1_flush_memwb", flush_memwb, 1);
    check("mw1_busy", busy, 0);
    apply(2'b00, 0, 0, 0, 1, 0, 0, 0);
    check("mw2_busy", busy, 1);
    check("mw2_stall_ifid", stall_ifid, 1);
    apply(2'b00, 0, 0, 0, 1, 0, 0, 0);
    apply(2'b00, 0, 0, 0, 1, 1, 0, 0);
    check("mw_rel_stall_ifid", stall_ifid, 0);
    check("mw_rel_flush_memwb", flush_memwb, 0);
    check("mw_rel_busy", busy, 1);
    idle();
    check("mw_done_busy", busy, 0);

    // Mispredict from slot 0
    apply(2'b00, 1, 0, 0, 0, 0, 0, 0);
    check("bp0_sel_exmem", sel_exmem, 1);
    check("bp0_flush_exmem", flush_exmem, 1);
    check("bp0_flush_idex", flush_idex, 1);
    idle();
    check("bp0_c1_flush_ifid", flush_ifid, 1);
    check("bp0_c1_flush_idex", flush_idex, 0);
    check("bp0_c1_busy", busy, 1);
    idle();
    check("bp0_c2_flush_ifid", flush_ifid, 1);
    idle();
    check("bp0_c3_flush_ifid", flush_ifid, 0);
    check("bp0_c3_busy", busy, 0);

    // Mispredict from slot 1: EX/MEM untouched
    apply(2'b00, 1, 1, 0, 0, 0, 0, 0);
    check("bp1_flush_exmem", flush_exmem, 0);
    check("bp1_sel_exmem", sel_exmem, 0);
    idle();
    idle();
    idle();

    // Trap and mispredict together during MEM_WAIT
    apply(2'b00, 0, 0, 0, 1, 0, 0, 0);
    apply(2'b00, 0, 0, 0, 1, 0, 0, 0);
    apply(2'b00, 1, 0, 1, 1, 0, 0, 0);
    check("pri_flush_memwb", flush_memwb, 1);
    check("pri_flush_exmem", flush_exmem, 1);
    check("pri_sel_exmem", sel_exmem, 0);
    check("pri_stall_ifid", stall_ifid, 0);
    check("pri_stall_exmem", stall_exmem, 0);
    idle();
    check("pri_redir_busy", busy, 1);
    check("pri_redir_flush_ifid", flush_ifid, 1);
    idle();
    idle();
    check("pri_back_busy", busy, 0);

    // MDU: start at cycle 0, done at cycle 5
    apply(2'b00, 0, 0, 0, 0, 0, 1, 0);
    check("mdu_c0_stall_ifid", stall_ifid, 1);
    check("mdu_c0_flush_exmem", flush_exmem, 1);
    check("mdu_c0_sel_exmem", sel_exmem, 0);
    idle();
    idle();
    idle();
    idle();
    check("mdu_c4_stall_idex", stall_idex, 1);
    apply(2'b00, 0, 0, 0, 0, 0, 0, 1);
    check("mdu_c5_stall_ifid", stall_ifid, 0);
    check("mdu_c5_busy", busy, 1);
    idle();
    check("mdu_after_busy", busy, 0);
    apply(2'b00, 0, 0, 0, 0, 0, 1, 1);
    check("mdu_same_stall_ifid", stall_ifid, 0);
    check("mdu_same_flush_exmem", flush_exmem, 0);
    idle();
    check("mdu_same_busy", busy, 0);

    // Memory wait during REDIRECT: counter frozen, IF/ID flushed not stalled
    apply(2'b00, 1, 1, 0, 0, 0, 0, 0);
    apply(2'b00, 0, 0, 0, 1, 0, 0, 0);
    check("rmw_stall_ifid", stall_ifid, 0);
    check("rmw_flush_ifid", flush_ifid, 1);
    check("rmw_stall_idex", stall_idex, 1);
    check("rmw_flush_memwb", flush_memwb, 1);
    apply(2'b00, 0, 0, 0, 1, 0, 0, 0);
    apply(2'b00, 0, 0, 0, 1, 1, 0, 0);
    check("rmw_rel_flush_ifid", flush_ifid, 1);
    check("rmw_rel_stall_idex", stall_idex, 0);
    idle();
    check("rmw_last_flush_ifid", flush_ifid, 1);
    idle();
    check("rmw_back_busy", busy, 0);

    // Trap during MDU_BUSY together with mdu_done
    apply(2'b00, 0, 0, 0, 0, 0, 1, 0);
    idle();
    apply(2'b00, 0, 0, 1, 0, 0, 0, 1);
    check("tmdu_flush_ifid", flush_ifid, 1);
    check("tmdu_flush_memwb", flush_memwb, 1);
    check("tmdu_stall_ifid", stall_ifid, 0);
    idle();
    check("tmdu_redir_busy", busy, 1);
    idle();
    idle();
    check("tmdu_back_busy", busy, 0);

    // Reset asserted in the middle of a memory wait
    apply(2'b00, 0, 0, 0, 1, 0, 0, 0);
    apply(2'b00, 0, 0, 0, 1, 0, 0, 0);
    set_rst(1'b0);
    check("rmid_stall_ifid", stall_ifid, 0);
    check("rmid_flush_memwb", flush_memwb, 0);
    check("rmid_busy", busy, 0);
    idle();
    set_rst(1'b1);
    check("rrel_busy", busy, 0);
    check("rrel_stall_ifid", stall_ifid, 0);
`ifdef PIPE_CTRL_PERF_EN
    check("rrel_perf_stall", perf_stall_cyc, 0);
    check("rrel_perf_flush", perf_flush_cyc, 0);
`endif
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
